// File: rtl/count_seq_checker.sv
// Observer for an up/down counter: predicts each step from the previous sample,
// flags and tallies mismatches, reports wrap-around and latches a fault.
module count_seq_checker #(
  parameter int WIDTH   = 4,
  parameter int ERR_W   = 8,
  parameter int MAX_ERR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_rst,
  input  logic             up,
  input  logic [WIDTH-1:0] count,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fault,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [WIDTH-1:0] bad_val,
  output logic [WIDTH-1:0] exp_val
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev_cnt;
  logic             r_prev_up;
  logic             r_prev_rst;
  logic [ERR_W-1:0] r_consec;
  logic             r_captured;

  logic [WIDTH-1:0] w_exp;
  logic             w_mismatch;
  logic             w_wrap_up;
  logic             w_wrap_dn;

  // A sampled counter reset forces the next expected value to zero.
  always_comb begin
    w_exp = '0;
    if (!r_prev_rst)
      w_exp = r_prev_up ? r_prev_cnt + 1'b1 : r_prev_cnt - 1'b1;
    w_mismatch = (count != w_exp);
    w_wrap_up  = !r_prev_rst && r_prev_up && (r_prev_cnt == '1) && (count == '0);
    w_wrap_dn  = !r_prev_rst && !r_prev_up && (r_prev_cnt == '0) && (count == '1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_prev_cnt <= '0;
      r_prev_up  <= 1'b0;
      r_prev_rst <= 1'b0;
      r_consec   <= '0;
      r_captured <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      fault      <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      bad_val    <= '0;
      exp_val    <= '0;
    end else begin
      r_prev_cnt <= count;
      r_prev_up  <= up;
      r_prev_rst <= cnt_rst;
      err        <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      if (clr) begin
        r_state    <= IDLE;
        r_consec   <= '0;
        r_captured <= 1'b0;
        locked     <= 1'b0;
        err_cnt    <= '0;
        fault      <= 1'b0;
        bad_val    <= '0;
        exp_val    <= '0;
      end else begin
        case (r_state)
          IDLE:    r_state <= ACQUIRE;
          ACQUIRE: begin
            r_state <= TRACK;
            locked  <= 1'b1;
          end
          TRACK: begin
            wrap_up <= w_wrap_up;
            wrap_dn <= w_wrap_dn;
            if (w_mismatch) begin
              err      <= 1'b1;
              r_consec <= r_consec + 1'b1;
              if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
              if (!r_captured) begin
                r_captured <= 1'b1;
                bad_val    <= count;
                exp_val    <= w_exp;
              end
              if (r_consec + 1'b1 >= ERR_W'(MAX_ERR)) begin
                r_state <= FAULT;
                fault   <= 1'b1;
                locked  <= 1'b0;
              end
            end else begin
              r_consec <= '0;
            end
          end
          FAULT: begin
            fault  <= 1'b1;
            locked <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
